// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults, state encoding and entry layout for the fetch sequencer
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 64;
    localparam int FETCH_INSTR_W = 32;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

    // A buffered entry is packed as {pc, instr}, pc in the upper bits.
    function automatic int fetch_entry_w(input int addr_w, input int instr_w);
        return addr_w + instr_w;
    endfunction

    localparam int FETCH_ENTRY_W = fetch_entry_w(FETCH_ADDR_W, FETCH_INSTR_W);

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO skid buffer with push, pop, flush and zeroed head when empty
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int W = FETCH_ENTRY_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output logic [W-1:0] o_head
);

    logic [W-1:0] r_e0;
    logic [W-1:0] r_e1;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    // Self-guarded so an illegal pop on empty or push on full is ignored.
    assign w_pop  = i_pop & (r_count != 2'd0);
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_data;
                    else                 r_e1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_e0 <= r_e1;
                        r_e1 <= i_data;
                    end else begin
                        r_e0 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != 2'd0) ? r_e0 : '0;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC, run/halt state and redirect control over a 2-entry fetch buffer; FETCH_PERF_EN adds perf counters
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = FETCH_ADDR_W,
    parameter int                INSTR_W  = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
`ifdef FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall,
`endif
    output logic               halted
);

    localparam int                EW         = fetch_entry_w(ADDR_W, INSTR_W);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP - ADDR_W'(1));

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_halted;
    logic [1:0]        w_count;
    logic [EW-1:0]     w_head;
    logic              w_pop;
    logic              w_push;

    assign out_valid = (w_count != 2'd0);
    assign w_pop     = out_valid & out_ready;
    assign w_push    = (r_state == FETCH_RUN) & ~halt & ~redirect_valid
                     & ((w_count != 2'd2) | w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_state  <= FETCH_RUN;
            r_halted <= 1'b0;
        end else begin
            if (redirect_valid)
                r_pc <= redirect_pc & ALIGN_MASK;
            else if (w_push)
                r_pc <= r_pc + STEP;

            case (r_state)
                FETCH_RUN: if (halt) begin
                    r_state  <= FETCH_HALTED;
                    r_halted <= 1'b1;
                end
                FETCH_HALTED: if (!halt) begin
                    r_state  <= FETCH_RUN;
                    r_halted <= 1'b0;
                end
                default: begin
                    r_state  <= FETCH_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    fetch_buffer #(.W(EW)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({r_pc, imem_instr}),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_addr = r_pc;
    assign out_pc    = w_head[EW-1 -: ADDR_W];
    assign out_instr = w_head[INSTR_W-1:0];
    assign halted    = r_halted;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    assign w_stall = (r_state == FETCH_RUN) & ~redirect_valid & ~w_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_push && r_perf_fetched != 32'hFFFF_FFFF)
                r_perf_fetched <= r_perf_fetched + 32'd1;
            if (w_stall && r_perf_stall != 32'hFFFF_FFFF)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    int total = 0;
    int bad   = 0;

    assign imem_instr = imem_addr[31:0] ^ 32'hA5A5A5A5;

    fetch_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
`ifdef FETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .halted         (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; out_ready = 1'b1; halt = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 64'd0;
        #3;
        chk("rst_addr",   imem_addr, 64'd0);
        chk("rst_valid",  64'(out_valid), 64'd0);
        chk("rst_instr",  64'(out_instr), 64'd0);
        chk("rst_pc",     out_pc, 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // streaming with decode always ready
        step;
        chk("s1_addr",  imem_addr, 64'd4);
        chk("s1_valid", 64'(out_valid), 64'd1);
        chk("s1_pc",    out_pc, 64'd0);
        chk("s1_instr", 64'(out_instr), 64'h0000_0000_A5A5_A5A5);
        step;
        chk("s2_addr",  imem_addr, 64'd8);
        chk("s2_pc",    out_pc, 64'd4);
        chk("s2_instr", 64'(out_instr), 64'h0000_0000_A5A5_A5A1);

        // backpressure fills the buffer, then drains in order
        out_ready = 1'b0; do_reset;
        repeat (5) step;
        chk("bp_addr",  imem_addr, 64'd8);
        chk("bp_pc",    out_pc, 64'd0);
        chk("bp_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        step;
        chk("dr_pc4", out_pc, 64'd4);
        step;
        chk("dr_pc8",    out_pc, 64'd8);
        chk("dr_instr8", 64'(out_instr), 64'h0000_0000_A5A5_A5AD);
        chk("dr_addr",   imem_addr, 64'd16);

        // redirect with full buffer, unaligned target
        out_ready = 1'b0; do_reset;
        repeat (3) step;
        chk("rd_full_addr", imem_addr, 64'd8);
        redirect_valid = 1'b1; redirect_pc = 64'h103;
        step;
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_addr",  imem_addr, 64'h100);
        redirect_valid = 1'b0; out_ready = 1'b1;
        step;
        chk("rd_pc",    out_pc, 64'h100);
        chk("rd_valid2", 64'(out_valid), 64'd1);
        chk("rd_addr2", imem_addr, 64'h104);

        // halt drains the buffer and freezes the PC
        out_ready = 1'b0; do_reset;
        repeat (2) step;
        halt = 1'b1; out_ready = 1'b1;
        step;
        chk("h_pc4",    out_pc, 64'd4);
        chk("h_halted", 64'(halted), 64'd1);
        chk("h_addr",   imem_addr, 64'd8);
        step;
        chk("h_empty",  64'(out_valid), 64'd0);
        repeat (2) step;
        chk("h_empty2", 64'(out_valid), 64'd0);
        chk("h_addr2",  imem_addr, 64'd8);
        chk("h_halted2", 64'(halted), 64'd1);
        halt = 1'b0;
        step;
        chk("h_run",    64'(halted), 64'd0);
        chk("h_valid3", 64'(out_valid), 64'd0);
        chk("h_addr3",  imem_addr, 64'd8);
        step;
        chk("h_resume_pc", out_pc, 64'd8);
        chk("h_resume_addr", imem_addr, 64'd12);

        // simultaneous redirect and halt
        redirect_valid = 1'b1; redirect_pc = 64'h200; halt = 1'b1;
        step;
        chk("rh_valid",  64'(out_valid), 64'd0);
        chk("rh_addr",   imem_addr, 64'h200);
        chk("rh_halted", 64'(halted), 64'd1);

        // redirect while halted, then PC wrap
        halt = 1'b0; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        step;
        chk("wr_addr",   imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_halted", 64'(halted), 64'd0);
        redirect_valid = 1'b0;
        step;
        chk("wr_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wr_addr0",  imem_addr, 64'd0);
        step;
        chk("wr_pc0",    out_pc, 64'd0);
        chk("wr_addr4",  imem_addr, 64'd4);

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_pc",    out_pc, 64'd0);
        chk("ar_instr", 64'(out_instr), 64'd0);
        chk("ar_addr",  imem_addr, 64'd0);
        @(negedge clk);
        reset = 1'b0;

`ifdef FETCH_PERF_EN
        out_ready = 1'b1;
        chk("pf_fetch0", 64'(perf_fetched), 64'd0);
        repeat (9) step;
        out_ready = 1'b0;
        step;
        repeat (3) step;
        chk("pf_fetched", 64'(perf_fetched), 64'd10);
        chk("pf_stall",   64'(perf_stall), 64'd3);
        #2 reset = 1'b1;
        #1;
        chk("pf_rst_fetched", 64'(perf_fetched), 64'd0);
        chk("pf_rst_stall",   64'(perf_stall), 64'd0);
        chk("pf_rst_valid",   64'(out_valid), 64'd0);
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
